duty_cycle_meter: RTL and testbench

//  Downstream consumer of the clock_d duty-cycle generator. Samples the generated waveform on a

---
 rtl/duty_cycle_meter.sv | 217 +++++++++++++++++++++
 tb/tb_duty_cycle_meter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/duty_cycle_meter.sv
// Measures high time, low time and period of an asynchronous waveform in clk cycles,
// and derives integer duty percent with a bit-serial restoring divider.
module duty_cycle_meter #(
  parameter int CW          = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sig_in,
  output logic [CW-1:0] ton_cnt,
  output logic [CW-1:0] toff_cnt,
  output logic [CW-1:0] period_cnt,
  output logic [6:0]    duty_pct,
  output logic          valid,
  output logic          busy,
  output logic          ovf
);

  localparam int NW = CW + 7;
  localparam int RW = CW + 1;
  localparam int IW = $clog2(NW + 1);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_dly_q, s_dly_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          hcnt_q, hcnt_d;
  logic [CW-1:0]          lcnt_q, lcnt_d;
  logic [CW-1:0]          snap_h_q, snap_h_d;
  logic [CW-1:0]          snap_l_q, snap_l_d;
  logic                   busy_q, busy_d;
  logic [IW-1:0]          iter_q, iter_d;
  logic [NW-1:0]          num_q, num_d;
  logic [RW-1:0]          rem_q, rem_d;
  logic [CW-1:0]          den_q, den_d;
  logic [CW-1:0]          ton_q, ton_d;
  logic [CW-1:0]          toff_q, toff_d;
  logic [CW-1:0]          period_q, period_d;
  logic [6:0]             duty_q, duty_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;

  logic          s, rise, fall;
  logic [CW:0]   sum_ext;
  logic          snap_take;
  logic [RW:0]   rem_sh;
  logic          q_bit;
  logic [NW-1:0] num_step;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_dly_q;
  assign fall    = ~s & s_dly_q;
  assign sum_ext = {1'b0, hcnt_q} + {1'b0, lcnt_q};

  // One restoring step: quotient bits shift into num_q from the bottom as the
  // numerator drains out of the top, so num_q ends up holding the quotient.
  assign rem_sh   = {rem_q, num_q[NW-1]};
  assign q_bit    = (rem_sh >= {2'b00, den_q});
  assign num_step = {num_q[NW-2:0], q_bit};

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
    s_dly_d   = s;
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    lcnt_d    = lcnt_q;
    snap_h_d  = snap_h_q;
    snap_l_d  = snap_l_q;
    busy_d    = busy_q;
    iter_d    = iter_q;
    num_d     = num_q;
    rem_d     = rem_q;
    den_d     = den_q;
    ton_d     = ton_q;
    toff_d    = toff_q;
    period_d  = period_q;
    duty_d    = duty_q;
    valid_d   = 1'b0;
    ovf_d     = 1'b0;
    snap_take = 1'b0;

    if (!en) begin
      state_d = IDLE;
      hcnt_d  = '0;
      lcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = HIGH;
            hcnt_d  = CW'(1);
            lcnt_d  = '0;
          end
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
            lcnt_d  = CW'(1);
          end else if (hcnt_q == CMAX) begin
            ovf_d   = 1'b1;
            state_d = IDLE;
            hcnt_d  = '0;
            lcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + CW'(1);
          end
        end
        LOW: begin
          if (rise) begin
            if (sum_ext[CW]) begin
              ovf_d   = 1'b1;
              state_d = IDLE;
              hcnt_d  = '0;
              lcnt_d  = '0;
            end else begin
              // A period completing while the divider is still busy is dropped;
              // measurement of the following period carries on regardless.
              if (busy_q) ovf_d = 1'b1;
              else        snap_take = 1'b1;
              state_d = HIGH;
              hcnt_d  = CW'(1);
              lcnt_d  = '0;
            end
          end else if (lcnt_q == CMAX) begin
            ovf_d   = 1'b1;
            state_d = IDLE;
            hcnt_d  = '0;
            lcnt_d  = '0;
          end else begin
            lcnt_d = lcnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (!en) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      num_d  = num_step;
      rem_d  = q_bit ? RW'(rem_sh - {2'b00, den_q}) : rem_sh[RW-1:0];
      iter_d = iter_q + IW'(1);
      if (iter_q == IW'(NW - 1)) begin
        busy_d   = 1'b0;
        valid_d  = 1'b1;
        ton_d    = snap_h_q;
        toff_d   = snap_l_q;
        period_d = den_q;
        duty_d   = num_step[6:0];
      end
    end

    if (snap_take) begin
      snap_h_d = hcnt_q;
      snap_l_d = lcnt_q;
      num_d    = {7'd0, hcnt_q} * NW'(100);
      den_d    = sum_ext[CW-1:0];
      rem_d    = '0;
      iter_d   = '0;
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      s_dly_q  <= 1'b0;
      state_q  <= IDLE;
      hcnt_q   <= '0;
      lcnt_q   <= '0;
      snap_h_q <= '0;
      snap_l_q <= '0;
      busy_q   <= 1'b0;
      iter_q   <= '0;
      num_q    <= '0;
      rem_q    <= '0;
      den_q    <= '0;
      ton_q    <= '0;
      toff_q   <= '0;
      period_q <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      s_dly_q  <= s_dly_d;
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      lcnt_q   <= lcnt_d;
      snap_h_q <= snap_h_d;
      snap_l_q <= snap_l_d;
      busy_q   <= busy_d;
      iter_q   <= iter_d;
      num_q    <= num_d;
      rem_q    <= rem_d;
      den_q    <= den_d;
      ton_q    <= ton_d;
      toff_q   <= toff_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ton_cnt    = ton_q;
  assign toff_cnt   = toff_q;
  assign period_cnt = period_q;
  assign duty_pct   = duty_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Directed bench for duty_cycle_meter: a CW=16 instance for most cases and a CW=8
// instance for counter saturation.
module tb_duty_cycle_meter;

  logic clk = 1'b0;
  logic rst, en, sig_in, en8, sig8;

  always #5 clk = ~clk;

  logic [15:0] ton_cnt, toff_cnt, period_cnt;
  logic [6:0]  duty_pct;
  logic        valid, busy, ovf;
  logic [7:0]  ton8, toff8, period8;
  logic [6:0]  duty8;
  logic        valid8, busy8, ovf8;

  duty_cycle_meter #(.CW(16), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .ton_cnt(ton_cnt), .toff_cnt(toff_cnt), .period_cnt(period_cnt),
    .duty_pct(duty_pct), .valid(valid), .busy(busy), .ovf(ovf)
  );

  duty_cycle_meter #(.CW(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .en(en8), .sig_in(sig8),
    .ton_cnt(ton8), .toff_cnt(toff8), .period_cnt(period8),
    .duty_pct(duty8), .valid(valid8), .busy(busy8), .ovf(ovf8)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int v_n = 0, o_n = 0, v8_n = 0, o8_n = 0;
  int hold_err = 0, hold8_err = 0;
  int last_ton, last_toff, last_period, last_duty;
  int last_ton8, last_toff8, last_period8, last_duty8;
  bit phase6 = 1'b0;
  logic [54:0] prev_res;
  logic [30:0] prev_res8;

  task automatic check_eq(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      tick(hi);
      sig_in = 1'b0;
      tick(lo);
    end
  endtask

  task automatic idle_reset();
    en = 1'b0;
    sig_in = 1'b0;
    tick(4);
    en = 1'b1;
    tick(2);
  endtask

  // Record result pulses and flag any result change that arrives without valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        v_n++;
        last_ton    = int'(ton_cnt);
        last_toff   = int'(toff_cnt);
        last_period = int'(period_cnt);
        last_duty   = int'(duty_pct);
        $display("[TB] valid ton=%0d toff=%0d period=%0d duty=%0d", ton_cnt, toff_cnt, period_cnt, duty_pct);
        if (phase6) begin
          check_eq("t6_ton_in_4_5", int'(ton_cnt == 16'd4 || ton_cnt == 16'd5), 1);
          check_eq("t6_period_in_10_11", int'(period_cnt == 16'd10 || period_cnt == 16'd11), 1);
        end
      end else if ({ton_cnt, toff_cnt, period_cnt, duty_pct} != prev_res) begin
        hold_err++;
      end
      if (ovf) o_n++;
      if (valid8) begin
        v8_n++;
        last_ton8    = int'(ton8);
        last_toff8   = int'(toff8);
        last_period8 = int'(period8);
        last_duty8   = int'(duty8);
        $display("[TB] valid8 ton=%0d toff=%0d period=%0d duty=%0d", ton8, toff8, period8, duty8);
      end else if ({ton8, toff8, period8, duty8} != prev_res8) begin
        hold8_err++;
      end
      if (ovf8) o8_n++;
    end
    prev_res  = {ton_cnt, toff_cnt, period_cnt, duty_pct};
    prev_res8 = {ton8, toff8, period8, duty8};
  end

  int v0, o0;

  initial begin
    rst = 1'b1; en = 1'b0; sig_in = 1'b0; en8 = 1'b1; sig8 = 1'b0;
    tick(3);
    check_eq("rst_ton", int'(ton_cnt), 0);
    check_eq("rst_toff", int'(toff_cnt), 0);
    check_eq("rst_period", int'(period_cnt), 0);
    check_eq("rst_duty", int'(duty_pct), 0);
    check_eq("rst_valid", int'(valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_ovf", int'(ovf), 0);
    rst = 1'b0; en = 1'b1;
    tick(3);

    // Saturation on the CW=8 instance: 261 high cycles overflow hcnt.
    sig8 = 1'b1; tick(261);
    sig8 = 1'b0; tick(15);
    check_eq("t3_ovf_after_hold", o8_n, 1);
    check_eq("t3_no_valid_after_hold", v8_n, 0);
    for (int i = 0; i < 3; i++) begin
      sig8 = 1'b1; tick(5);
      sig8 = 1'b0; tick(15);
    end
    tick(30);
    check_eq("t3_valid_count", v8_n, 2);
    check_eq("t3_ovf_total", o8_n, 1);
    check_eq("t3_ton", last_ton8, 5);
    check_eq("t3_toff", last_toff8, 15);
    check_eq("t3_period", last_period8, 20);
    check_eq("t3_duty", last_duty8, 25);

    // 3 high / 7 low: divide takes 24 cycles, so two of every three snapshots collide.
    idle_reset();
    v0 = v_n; o0 = o_n;
    wave(3, 7, 5);
    tick(40);
    check_eq("t1_valid_count", v_n - v0, 2);
    check_eq("t1_ovf_count", o_n - o0, 2);
    check_eq("t1_ton", last_ton, 3);
    check_eq("t1_toff", last_toff, 7);
    check_eq("t1_period", last_period, 10);
    check_eq("t1_duty", last_duty, 30);

    // Duty sweep at period 100.
    idle_reset();
    o0 = o_n;
    for (int k = 1; k <= 8; k++) begin
      v0 = v_n;
      wave(10 * k, 100 - 10 * k, 3);
      check_eq($sformatf("t2_valid_count_%0d", 10 * k), v_n - v0, (k == 1) ? 2 : 3);
      check_eq($sformatf("t2_ton_%0d", 10 * k), last_ton, 10 * k);
      check_eq($sformatf("t2_period_%0d", 10 * k), last_period, 100);
      check_eq($sformatf("t2_duty_%0d", 10 * k), last_duty, 10 * k);
    end
    check_eq("t2_no_ovf", o_n - o0, 0);

    // Period 12: snapshot every 12, busy for 23 -> alternate accept / discard.
    idle_reset();
    v0 = v_n; o0 = o_n;
    wave(4, 8, 6);
    tick(40);
    check_eq("t4_valid_count", v_n - v0, 3);
    check_eq("t4_ovf_count", o_n - o0, 2);
    check_eq("t4_ton", last_ton, 4);
    check_eq("t4_toff", last_toff, 8);
    check_eq("t4_period", last_period, 12);
    check_eq("t4_duty", last_duty, 33);

    // Reset mid-divide, then en dropped mid-HIGH.
    idle_reset();
    v0 = v_n;
    wave(3, 7, 2);
    rst = 1'b1;
    tick(1);
    check_eq("t5_rst_ton", int'(ton_cnt), 0);
    check_eq("t5_rst_toff", int'(toff_cnt), 0);
    check_eq("t5_rst_period", int'(period_cnt), 0);
    check_eq("t5_rst_duty", int'(duty_pct), 0);
    check_eq("t5_rst_busy", int'(busy), 0);
    check_eq("t5_rst_valid", int'(valid), 0);
    tick(1);
    rst = 1'b0;
    tick(40);
    check_eq("t5_no_valid_after_rst", v_n - v0, 0);
    sig_in = 1'b1; tick(5);
    en = 1'b0; tick(2);
    en = 1'b1; tick(3);
    sig_in = 1'b0; tick(7);
    sig_in = 1'b1; tick(3);
    sig_in = 1'b0; tick(37);
    check_eq("t5_no_valid_before_2nd_rise", v_n - v0, 0);
    sig_in = 1'b1; tick(3);
    sig_in = 1'b0; tick(30);
    check_eq("t5_valid_count", v_n - v0, 1);
    check_eq("t5_ton", last_ton, 3);
    check_eq("t5_toff", last_toff, 37);
    check_eq("t5_period", last_period, 40);
    check_eq("t5_duty", last_duty, 7);

    // Asynchronous waveform: period 103 time units (10.3 clk), high 41.
    idle_reset();
    v0 = v_n;
    phase6 = 1'b1;
    repeat (14) begin
      sig_in = 1'b1; #41;
      sig_in = 1'b0; #62;
    end
    tick(30);
    phase6 = 1'b0;
    check_eq("t6_some_valid", int'(v_n - v0 > 0), 1);

    check_eq("hold_without_valid", hold_err, 0);
    check_eq("hold8_without_valid", hold8_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
